mux_byte_serializer: RTL and testbench

- Downstream stage of the 136-bit mux.
- Accepts one 136-bit word (mux data_out) per load handshake and streams it out as 17 bytes, MSB byte first, over a valid/ready byte interface.
- Feeds the byte-wide output/logging path.
- Tracks completed frames with a wrapping counter for debug and verification.

---
 rtl/mux_byte_serializer.sv | 122 ++++++++++++
 tb/tb_mux_byte_serializer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_byte_serializer.sv
// Serializes one DATA_W word per load handshake into MSB-first bytes; first byte valid 1 cycle after load, frame holds under byte_ready=0.
// Optional trailing XOR checksum beat when SER_CHECKSUM_EN is defined; one idle cycle separates frames.
module mux_byte_serializer #(
   parameter int DATA_W = 136,
   parameter int BYTE_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int NUM_BEATS = DATA_W / BYTE_W;
   localparam int BEAT_W    = $clog2(NUM_BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

`ifdef SER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SHIFT, CSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                load_fire;
   logic                data_fire;
   logic                last_data_beat;
`ifdef SER_CHECKSUM_EN
   logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

   assign load_fire      = (state_q == IDLE) && load_valid;
   assign data_fire      = (state_q == SHIFT) && byte_ready;
   assign last_data_beat = (beat_q == LAST_BEAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
`ifdef SER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
`ifdef SER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_valid) state_d = SHIFT;
`ifdef SER_CHECKSUM_EN
         SHIFT:   if (byte_ready && last_data_beat) state_d = CSUM;
         CSUM:    if (byte_ready) state_d = IDLE;
`else
         SHIFT:   if (byte_ready && last_data_beat) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Shifting left with zero fill leaves byte_out at 0 once the frame drains.
   always_comb begin
      shift_d = shift_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
`ifdef SER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (load_fire) begin
         shift_d = data_in;
         beat_d  = '0;
`ifdef SER_CHECKSUM_EN
         csum_d  = '0;
`endif
      end else if (data_fire) begin
         shift_d = shift_q << BYTE_W;
         beat_d  = beat_q + 1'b1;
`ifdef SER_CHECKSUM_EN
         csum_d  = csum_q ^ shift_q[DATA_W-1 -: BYTE_W];
`else
         if (last_data_beat) cnt_d = cnt_q + 1'b1;
`endif
      end
`ifdef SER_CHECKSUM_EN
      if ((state_q == CSUM) && byte_ready) cnt_d = cnt_q + 1'b1;
`endif
   end

   always_comb begin
      load_ready = (state_q == IDLE);
      byte_valid = (state_q != IDLE);
      busy       = (state_q != IDLE);
      frame_cnt  = cnt_q;
`ifdef SER_CHECKSUM_EN
      byte_last  = (state_q == CSUM);
      byte_out   = (state_q == CSUM) ? csum_q : shift_q[DATA_W-1 -: BYTE_W];
`else
      byte_last  = (state_q == SHIFT) && last_data_beat;
      byte_out   = shift_q[DATA_W-1 -: BYTE_W];
`endif
   end

endmodule

// File: tb/tb_mux_byte_serializer.sv
// Bench for mux_byte_serializer: vector table for clean and stalled frames, then a byte-queue reference model.
module tb_mux_byte_serializer;

`ifdef SER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int NB = 17 + CS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_valid;
   logic         load_ready;
   logic [135:0] data_in;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic         byte_ready;
   logic         byte_last;
   logic         busy;
   logic [15:0]  frame_cnt;

   mux_byte_serializer dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
      .data_in(data_in), .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         lv;
      logic [135:0] din;
      logic         br;
      logic         e_vld;
      logic [7:0]   e_byte;
      logic         e_last;
      logic         e_lrdy;
      logic [15:0]  e_cnt;
   } vec_t;

   vec_t        tbl[$];
   logic [7:0]  mq[$];
   logic [15:0] mcnt;
   int          n_vec = 0;
   int          n_err = 0;

   localparam logic [135:0] W_A = 136'h0123456789abcdef0123456789abcdef;
   localparam logic [135:0] W_B = 136'hfedcba9876543210fedcba9876543210;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected beats of a frame: 17 data bytes MSB first, plus the XOR byte when enabled.
   task automatic frame_bytes(input logic [135:0] w, output logic [7:0] b[18]);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 17; i++) begin
         b[i] = w[135 - 8*i -: 8];
         x ^= b[i];
      end
      b[17] = x;
   endtask

   task automatic add(input logic lv, input logic [135:0] din, input logic br, input logic vld,
                      input logic [7:0] by, input logic last, input logic lrdy, input logic [15:0] cnt);
      vec_t v;
      v.lv = lv; v.din = din; v.br = br; v.e_vld = vld;
      v.e_byte = by; v.e_last = last; v.e_lrdy = lrdy; v.e_cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic build_frame(input logic [135:0] w, input int hold_k, input int hold_n, input logic [15:0] base);
      logic [7:0] b[18];
      int k, held;
      logic rdy;
      frame_bytes(w, b);
      add(1'b1, w, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, base);
      k = 0; held = 0;
      while (k < NB) begin
         rdy = !(k == hold_k && held < hold_n);
         add(1'b0, 136'h0, rdy, 1'b1, b[k], (k == NB-1), 1'b0, base);
         if (rdy) k++; else held++;
      end
      add(1'b0, 136'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, base + 16'd1);
   endtask

   task automatic model_load(input logic [135:0] w);
      logic [7:0] b[18];
      frame_bytes(w, b);
      for (int i = 0; i < NB; i++) mq.push_back(b[i]);
   endtask

   // One clock: drive after the edge, compare on the falling edge, then advance the model.
   task automatic step(input logic lv, input logic [135:0] din, input logic br);
      logic exp_busy;
      @(posedge clk); #1;
      load_valid = lv; data_in = din; byte_ready = br;
      @(negedge clk);
      exp_busy = (mq.size() > 0);
      chk("load_ready", {31'b0, load_ready}, {31'b0, !exp_busy});
      chk("byte_valid", {31'b0, byte_valid}, {31'b0, exp_busy});
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, mcnt});
      if (exp_busy) begin
         chk("byte_out", {24'b0, byte_out}, {24'b0, mq[0]});
         chk("byte_last", {31'b0, byte_last}, {31'b0, mq.size() == 1});
         if (br) begin
            void'(mq.pop_front());
            if (mq.size() == 0) mcnt++;
         end
      end else if (lv) begin
         model_load(din);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; load_valid = 1'b0; byte_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      mcnt = 16'd0;
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; byte_ready = 1'b0; data_in = '0;
      mq.delete(); mcnt = 16'd0;

      repeat (2) @(negedge clk);
      chk("rst_byte_valid", {31'b0, byte_valid}, 32'd0);
      chk("rst_byte_out", {24'b0, byte_out}, 32'd0);
      chk("rst_byte_last", {31'b0, byte_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_load_ready", {31'b0, load_ready}, 32'd1);
      chk("post_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
      chk("post_rst_byte_out", {24'b0, byte_out}, 32'd0);

      build_frame(W_A, -1, 0, 16'd0);
      build_frame(W_A, 3, 5, 16'd1);
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         load_valid = tbl[i].lv; data_in = tbl[i].din; byte_ready = tbl[i].br;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), {31'b0, byte_valid}, {31'b0, tbl[i].e_vld});
         chk($sformatf("tbl%0d_load_ready", i), {31'b0, load_ready}, {31'b0, tbl[i].e_lrdy});
         chk($sformatf("tbl%0d_frame_cnt", i), {16'b0, frame_cnt}, {16'b0, tbl[i].e_cnt});
         if (tbl[i].e_vld) begin
            chk($sformatf("tbl%0d_byte", i), {24'b0, byte_out}, {24'b0, tbl[i].e_byte});
            chk($sformatf("tbl%0d_last", i), {31'b0, byte_last}, {31'b0, tbl[i].e_last});
         end
      end

      // Load held high during a frame is ignored until idle; data changes after the handshake are ignored.
      mcnt = 16'd2;
      step(1'b1, W_A, 1'b1);
      for (int i = 0; i < NB + 1; i++) step(1'b1, W_B, 1'b1);
      for (int i = 0; i < NB + 3; i++) step(1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
      chk("busy_load_frames", {16'b0, frame_cnt}, 32'd4);

      for (int i = 0; i < 2500; i++)
         step(($urandom % 4) == 0, {$urandom, $urandom, $urandom, $urandom, $urandom}, ($urandom % 3) != 0);

      // Abort a frame with reset after beat 8; the count was 0 before the frame and must stay 0.
      do_reset();
      step(1'b1, W_B, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, W_A, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_byte_valid", {31'b0, byte_valid}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      mcnt = 16'd0;
      step(1'b1, W_A, 1'b1);
      for (int i = 0; i < NB + 2; i++) step(1'b0, 136'h0, 1'b1);
      chk("after_abort_frame_cnt", {16'b0, frame_cnt}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
